fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter BOOT_CYCLES, 1: idle cycles after reset release before the first fetch (range 1..15).
REQ-003 SYS_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SYS_reset  in  1  asynchronous, active-high reset.
REQ-005 imem_pc  out  32  fetch address driven to instruction memory; equals the internal PC register.
REQ-006 imem_instruction  in  32  combinational read data for imem_pc, valid in the same cycle.
REQ-007 stall  in  1  hazard hold; freezes the PC and the IF/ID register.
REQ-008 branch_taken  in  1  redirect request from execute.
REQ-009 branch_target  in  32  redirect address; sampled only when branch_taken=1.
REQ-010 if_id_valid  out  1  IF/ID register holds a real instruction.
REQ-011 if_id_pc  out  32  PC of the IF/ID instruction.
REQ-012 if_id_pc_plus4  out  32  if_id_pc+4, modulo 2^32.
REQ-013 if_id_instruction  out  32  instruction word; 32'h0000_0013 (NOP) whenever if_id_valid=0.
REQ-014 fetch_misaligned  out  1  sticky flag: a redirect target had bits [1:0]!=0.
REQ-015 halted  out  1  FSM in HALT.
REQ-016 fetch_count  out  32  count of instructions accepted into IF/ID.

Function
REQ-017 The FSM has states BOOT, RUN and HALT; the reset state is BOOT.
REQ-018 In BOOT, a 4-bit counter runs from 0, the PC holds, if_id_valid=0, and the FSM enters RUN on the edge where the counter reaches BOOT_CYCLES-1.
REQ-019 In BOOT, stall and branch_taken are ignored.
REQ-020 In RUN, with stall=0 and branch_taken=0, each edge loads IF/ID with {imem_pc, imem_pc+4, imem_instruction}, sets if_id_valid=1, sets PC<=PC+4 and increments fetch_count.
REQ-021 PC and PC+4 arithmetic is 32-bit unsigned with wrap; 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-022 In RUN, stall=1 with branch_taken=0 holds PC, IF/ID contents, if_id_valid and fetch_count unchanged.
REQ-023 branch_taken=1 with branch_target[1:0]==0, in RUN or HALT, sets PC<=branch_target, clears if_id_valid (inserts a bubble), leaves fetch_count unchanged and sets the FSM to RUN.
REQ-024 branch_taken has priority over stall.
REQ-025 branch_taken=1 with branch_target[1:0]!=0 sets fetch_misaligned=1, holds the PC, clears if_id_valid and sets the FSM to HALT.
REQ-026 When an accepted instruction (REQ-020) equals EBREAK (32'h0010_0073), it enters IF/ID normally and the FSM moves to HALT on the same edge.
REQ-027 In HALT, the PC holds, if_id_valid<=0 on every edge, and stall is ignored.
REQ-028 HALT exits only via an aligned redirect (REQ-023) or reset.
REQ-029 fetch_misaligned stays 1 until reset, including after an aligned redirect.
REQ-030 fetch_count wraps from 32'hFFFF_FFFF to 0.
REQ-031 imem_pc is driven directly from the PC register, with no combinational path from stall or branch_taken.

Reset
REQ-032 While SYS_reset=1, independent of SYS_clk: PC=RESET_PC, FSM=BOOT, boot counter=0, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=4, if_id_instruction=32'h0000_0013, fetch_misaligned=0, fetch_count=0.
REQ-033 halted=0 while SYS_reset=1.
REQ-034 Reset asserted mid-operation (stall, redirect or HALT in progress) produces exactly the REQ-032 and REQ-033 state, with no residual effect.

Verification
REQ-035 Reset release with BOOT_CYCLES=1 and memory words 0..3 = A,B,C,D -> one bubble cycle; then IF/ID shows (pc 0,A), (4,B), (8,C) on consecutive edges; fetch_count=3.
REQ-036 Stall held for 3 cycles while IF/ID holds pc 8 -> IF/ID, imem_pc=12 and fetch_count are unchanged for 3 edges; fetch then resumes at 12.
REQ-037 branch_taken=1 with target 32'h40 while stall=1 -> next edge: if_id_valid=0, instruction=NOP, imem_pc=32'h40; the following edge: IF/ID pc=32'h40.
REQ-038 Branch to 32'h42 -> fetch_misaligned=1 and halted=1; PC held; a subsequent branch to 32'h80 gives halted=0, imem_pc=32'h80, fetch_misaligned still 1.
REQ-039 Word at 32'h10 = 32'h0010_0073 -> IF/ID pc=32'h10 valid for one edge, then halted=1 and if_id_valid=0 persist for 5 cycles.
REQ-040 RESET_PC=32'hFFFF_FFFC, fetch two words -> IF/ID pc sequence FFFF_FFFC then 0000_0000, with if_id_pc_plus4=0 for the first; then assert SYS_reset asynchronously mid-cycle -> REQ-032 values appear before the next clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory and fills the
// IF/ID pipeline register, with a BOOT/RUN/HALT control FSM.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 1
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instruction,
  output logic        fetch_misaligned,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
  localparam logic [3:0]  BOOT_LAST   = 4'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [31:0] id_insn_q, id_insn_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic        target_aligned;
  logic        redirect;
  logic        accept;

  assign pc_plus4       = pc_q + 32'd4;
  assign target_aligned = (branch_target[1:0] == 2'b00);
  // Redirects are honoured in RUN and HALT only; BOOT ignores them.
  assign redirect       = branch_taken && (state_q != ST_BOOT);
  assign accept         = (state_q == ST_RUN) && !branch_taken && !stall;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken) begin
          state_d = target_aligned ? ST_RUN : ST_HALT;
        end else if (!stall && (imem_instruction == EBREAK_INSN)) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (branch_taken) state_d = target_aligned ? ST_RUN : ST_HALT;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Datapath next values
  always_comb begin
    boot_cnt_d    = boot_cnt_q;
    pc_d          = pc_q;
    valid_d       = valid_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_insn_d     = id_insn_q;
    misaligned_d  = misaligned_q;
    count_d       = count_q;

    if ((state_q == ST_BOOT) && (boot_cnt_q != BOOT_LAST)) begin
      boot_cnt_d = boot_cnt_q + 4'd1;
    end

    if (redirect) begin
      valid_d = 1'b0;
      if (target_aligned) begin
        pc_d = branch_target;
      end else begin
        misaligned_d = 1'b1;
      end
    end else if (accept) begin
      pc_d          = pc_plus4;
      valid_d       = 1'b1;
      id_pc_d       = pc_q;
      id_pc_plus4_d = pc_plus4;
      id_insn_d     = imem_instruction;
      count_d       = count_q + 32'd1;
    end else if (state_q == ST_HALT) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      boot_cnt_q    <= 4'd0;
      pc_q          <= RESET_PC;
      valid_q       <= 1'b0;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd4;
      id_insn_q     <= NOP_INSN;
      misaligned_q  <= 1'b0;
      count_q       <= 32'd0;
    end else begin
      boot_cnt_q    <= boot_cnt_d;
      pc_q          <= pc_d;
      valid_q       <= valid_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_insn_q     <= id_insn_d;
      misaligned_q  <= misaligned_d;
      count_q       <= count_d;
    end
  end

  // Outputs come straight from flops; the instruction mux only forces NOP on bubbles.
  always_comb begin
    imem_pc           = pc_q;
    if_id_valid       = valid_q;
    if_id_pc          = id_pc_q;
    if_id_pc_plus4    = id_pc_plus4_q;
    if_id_instruction = valid_q ? id_insn_q : NOP_INSN;
    fetch_misaligned  = misaligned_q;
    halted            = (state_q == ST_HALT);
    fetch_count       = count_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, redirect, misaligned halt,
// EBREAK halt, PC wrap and asynchronous reset, on two parameterisations.
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk;
  logic rst, rst2;
  logic [31:0] mem [64];

  logic        stall, br;
  logic [31:0] target;
  logic [31:0] pc1, insn1, id_pc1, id_p4_1, id_insn1, cnt1;
  logic        valid1, mis1, halt1;

  logic [31:0] pc2, insn2, id_pc2, id_p4_2, id_insn2, cnt2;
  logic        valid2, mis2, halt2;

  int vectors;
  int miscompares;

  assign insn1 = mem[pc1[7:2]];
  assign insn2 = mem[pc2[7:2]];

  fetch_stage #(.RESET_PC(32'h0000_0000), .BOOT_CYCLES(1)) u_dut (
    .SYS_clk(clk), .SYS_reset(rst),
    .imem_pc(pc1), .imem_instruction(insn1),
    .stall(stall), .branch_taken(br), .branch_target(target),
    .if_id_valid(valid1), .if_id_pc(id_pc1), .if_id_pc_plus4(id_p4_1),
    .if_id_instruction(id_insn1), .fetch_misaligned(mis1),
    .halted(halt1), .fetch_count(cnt1)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .BOOT_CYCLES(3)) u_dut2 (
    .SYS_clk(clk), .SYS_reset(rst2),
    .imem_pc(pc2), .imem_instruction(insn2),
    .stall(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
    .if_id_valid(valid2), .if_id_pc(id_pc2), .if_id_pc_plus4(id_p4_2),
    .if_id_instruction(id_insn2), .fetch_misaligned(mis2),
    .halted(halt2), .fetch_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset1(input string tag);
    check({tag, "_pc"},    pc1,                 32'h0000_0000);
    check({tag, "_valid"}, {31'd0, valid1},     32'd0);
    check({tag, "_idpc"},  id_pc1,              32'd0);
    check({tag, "_idp4"},  id_p4_1,             32'd4);
    check({tag, "_insn"},  id_insn1,            NOP);
    check({tag, "_mis"},   {31'd0, mis1},       32'd0);
    check({tag, "_halt"},  {31'd0, halt1},      32'd0);
    check({tag, "_cnt"},   cnt1,                32'd0);
  endtask

  task automatic check_if1(input string tag, input logic [31:0] epc,
                           input logic [31:0] einsn, input logic [31:0] ecnt);
    check({tag, "_valid"}, {31'd0, valid1}, 32'd1);
    check({tag, "_idpc"},  id_pc1,          epc);
    check({tag, "_idp4"},  id_p4_1,         epc + 32'd4);
    check({tag, "_insn"},  id_insn1,        einsn);
    check({tag, "_cnt"},   cnt1,            ecnt);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[4] = EBREAK;
    stall  = 1'b0;
    br     = 1'b0;
    target = 32'h0;
    rst    = 1'b1;
    rst2   = 1'b1;

    // Reset values before any clock edge
    #2;
    check_reset1("rst0");
    tick();
    tick();
    rst = 1'b0;

    // One bubble, then three sequential fetches
    tick();
    check("boot_valid", {31'd0, valid1}, 32'd0);
    check("boot_pc", pc1, 32'h0);
    tick(); check_if1("f0", 32'h0, 32'hA000_0000, 32'd1);
    tick(); check_if1("f4", 32'h4, 32'hA000_0001, 32'd2);
    tick(); check_if1("f8", 32'h8, 32'hA000_0002, 32'd3);
    check("f8_imem", pc1, 32'hC);

    // Stall for three edges
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_if1("stall", 32'h8, 32'hA000_0002, 32'd3);
      check("stall_imem", pc1, 32'hC);
    end
    stall = 1'b0;
    tick(); check_if1("resume", 32'hC, 32'hA000_0003, 32'd4);
    check("resume_imem", pc1, 32'h10);

    // Redirect beats stall
    stall = 1'b1; br = 1'b1; target = 32'h40;
    tick();
    check("br_valid", {31'd0, valid1}, 32'd0);
    check("br_insn", id_insn1, NOP);
    check("br_imem", pc1, 32'h40);
    check("br_cnt", cnt1, 32'd4);
    stall = 1'b0; br = 1'b0;
    tick(); check_if1("br_f40", 32'h40, 32'hA000_0010, 32'd5);

    // Misaligned redirect halts, stall ignored
    br = 1'b1; target = 32'h42;
    tick();
    check("mis_flag", {31'd0, mis1}, 32'd1);
    check("mis_halt", {31'd0, halt1}, 32'd1);
    check("mis_imem", pc1, 32'h44);
    check("mis_valid", {31'd0, valid1}, 32'd0);
    br = 1'b0; stall = 1'b1;
    tick();
    check("mis_hold_halt", {31'd0, halt1}, 32'd1);
    check("mis_hold_imem", pc1, 32'h44);
    check("mis_hold_cnt", cnt1, 32'd5);
    stall = 1'b0;

    // Aligned redirect exits HALT, sticky flag remains
    br = 1'b1; target = 32'h80;
    tick();
    check("exit_halt", {31'd0, halt1}, 32'd0);
    check("exit_imem", pc1, 32'h80);
    check("exit_mis", {31'd0, mis1}, 32'd1);
    br = 1'b0;
    tick(); check_if1("f80", 32'h80, 32'hA000_0020, 32'd6);

    // EBREAK at 0x10
    br = 1'b1; target = 32'h10;
    tick();
    check("eb_br_imem", pc1, 32'h10);
    br = 1'b0;
    tick(); check_if1("eb_f10", 32'h10, EBREAK, 32'd7);
    check("eb_halt", {31'd0, halt1}, 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("eb_hold_halt", {31'd0, halt1}, 32'd1);
      check("eb_hold_valid", {31'd0, valid1}, 32'd0);
      check("eb_hold_imem", pc1, 32'h14);
      check("eb_hold_cnt", cnt1, 32'd7);
    end
    stall = 1'b0;

    // Asynchronous reset mid-cycle while halted with the sticky flag set
    #3 rst = 1'b1;
    #1 check_reset1("rst_mid");
    tick();
    rst = 1'b0;
    tick();
    check("rerun_boot_valid", {31'd0, valid1}, 32'd0);
    tick(); check_if1("rerun_f0", 32'h0, 32'hA000_0000, 32'd1);

    // Wrapping PC, BOOT_CYCLES=3
    rst2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w_boot_valid", {31'd0, valid2}, 32'd0);
      check("w_boot_imem", pc2, 32'hFFFF_FFFC);
    end
    tick();
    check("w_f0_valid", {31'd0, valid2}, 32'd1);
    check("w_f0_pc", id_pc2, 32'hFFFF_FFFC);
    check("w_f0_p4", id_p4_2, 32'h0);
    check("w_f0_insn", id_insn2, 32'hA000_003F);
    check("w_f0_imem", pc2, 32'h0);
    tick();
    check("w_f1_pc", id_pc2, 32'h0);
    check("w_f1_p4", id_p4_2, 32'h4);
    check("w_f1_insn", id_insn2, 32'hA000_0000);
    check("w_f1_cnt", cnt2, 32'd2);

    #3 rst2 = 1'b1;
    #1;
    check("w_rst_imem", pc2, 32'hFFFF_FFFC);
    check("w_rst_valid", {31'd0, valid2}, 32'd0);
    check("w_rst_idpc", id_pc2, 32'd0);
    check("w_rst_idp4", id_p4_2, 32'd4);
    check("w_rst_insn", id_insn2, NOP);
    check("w_rst_cnt", cnt2, 32'd0);
    check("w_rst_halt", {31'd0, halt2}, 32'd0);
    check("w_rst_mis", {31'd0, mis2}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
